// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encodings (also used by the control decoder and hazard unit) and the
// sequencer state encoding.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } md_state_e;

  // Divide operations have the upper encoding bit set.
  function automatic logic md_is_div(input md_op_e op);
    return op[1];
  endfunction

  // Signed operations have the lower encoding bit clear.
  function automatic logic md_is_signed(input md_op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Final result correction: turns the unsigned magnitude result of the
// iterative datapath into the architectural {Hi, Lo} value, applying
// operand signs and the divide-by-zero convention.
module muldiv_sign_fix
  import muldiv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2*DATA_W-1:0] raw_result,
  input  md_op_e              op,
  input  logic                sign_a,
  input  logic                sign_b,
  input  logic                div_by_zero,
  input  logic [DATA_W-1:0]   a_orig,
  output logic [2*DATA_W-1:0] result
);

  function automatic logic [DATA_W-1:0] neg_w(input logic [DATA_W-1:0] v);
    return ~v + {{(DATA_W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*DATA_W-1:0] neg_2w(input logic [2*DATA_W-1:0] v);
    return ~v + {{(2*DATA_W-1){1'b0}}, 1'b1};
  endfunction

  logic [DATA_W-1:0] quo_s;
  logic [DATA_W-1:0] rem_s;

  // Select the corrected result for the current operation.
  always_comb begin
    result = raw_result;
    quo_s  = raw_result[DATA_W-1:0];
    rem_s  = raw_result[2*DATA_W-1:DATA_W];
    case (op)
      MD_MULT: begin
        if (sign_a ^ sign_b) begin
          result = neg_2w(raw_result);
        end else begin
          result = raw_result;
        end
      end
      MD_MULTU: begin
        result = raw_result;
      end
      MD_DIV: begin
        if (div_by_zero) begin
          result = {a_orig, {DATA_W{1'b1}}};
        end else begin
          // Quotient sign follows sA^sB, remainder follows the dividend.
          if (sign_a ^ sign_b) begin
            quo_s = neg_w(raw_result[DATA_W-1:0]);
          end else begin
            quo_s = raw_result[DATA_W-1:0];
          end
          if (sign_a) begin
            rem_s = neg_w(raw_result[2*DATA_W-1:DATA_W]);
          end else begin
            rem_s = raw_result[2*DATA_W-1:DATA_W];
          end
          result = {rem_s, quo_s};
        end
      end
      MD_DIVU: begin
        if (div_by_zero) begin
          result = {a_orig, {DATA_W{1'b1}}};
        end else begin
          result = raw_result;
        end
      end
      default: begin
        result = raw_result;
      end
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One radix-2 step per cycle; fixed latency of DATA_W+1 cycles from the
// accepted Start to the Done pulse. Busy stalls the pipeline meanwhile.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [1:0]        Op,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic              Flush,
  input  logic              HiWrite,
  input  logic              LoWrite,
  input  logic [DATA_W-1:0] WrData,
  output logic              Busy,
  output logic              Done,
  output logic [DATA_W-1:0] Hi,
  output logic [DATA_W-1:0] Lo
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  md_state_e           state_r;
  md_state_e           state_s;
  md_op_e              op_s;
  md_op_e              op_r;
  logic                sign_a_r;
  logic                sign_b_r;
  logic                dbz_r;
  logic [DATA_W-1:0]   a_orig_r;
  logic [DATA_W-1:0]   opnd_r;      // |A| for multiply, |B| for divide
  logic [2*DATA_W-1:0] acc_r;       // product, or {unused, dividend/quotient}
  logic [DATA_W-1:0]   rem_r;       // partial remainder (always < divisor)
  logic [CNT_W-1:0]    cnt_r;
  logic                busy_r;
  logic                done_r;
  logic [DATA_W-1:0]   hi_r;
  logic [DATA_W-1:0]   lo_r;

  logic                sign_a_s;
  logic                sign_b_s;
  logic [DATA_W-1:0]   abs_a_s;
  logic [DATA_W-1:0]   abs_b_s;
  logic                dbz_s;
  logic [DATA_W:0]     mul_sum_s;
  logic [2*DATA_W-1:0] mul_next_s;
  logic [DATA_W:0]     rem_shift_s; // working remainder is one bit wider
  logic [DATA_W:0]     rem_diff_s;
  logic [DATA_W-1:0]   rem_next_s;
  logic [DATA_W-1:0]   quo_next_s;
  logic [2*DATA_W-1:0] raw_s;
  logic [2*DATA_W-1:0] fixed_s;

  assign op_s = md_op_e'(Op);

  // Operand preparation at launch: magnitudes and sign flags.
  always_comb begin
    sign_a_s = md_is_signed(op_s) & A[DATA_W-1];
    sign_b_s = md_is_signed(op_s) & B[DATA_W-1];
    if (sign_a_s) begin
      abs_a_s = ~A + {{(DATA_W-1){1'b0}}, 1'b1};
    end else begin
      abs_a_s = A;
    end
    if (sign_b_s) begin
      abs_b_s = ~B + {{(DATA_W-1){1'b0}}, 1'b1};
    end else begin
      abs_b_s = B;
    end
    dbz_s = md_is_div(op_s) & (B == {DATA_W{1'b0}});
  end

  // One radix-2 step: shift-add multiply and restoring shift-subtract divide.
  always_comb begin
    if (acc_r[0]) begin
      mul_sum_s = {1'b0, acc_r[2*DATA_W-1:DATA_W]} + {1'b0, opnd_r};
    end else begin
      mul_sum_s = {1'b0, acc_r[2*DATA_W-1:DATA_W]};
    end
    mul_next_s  = {mul_sum_s, acc_r[DATA_W-1:1]};
    rem_shift_s = {rem_r, acc_r[DATA_W-1]};
    rem_diff_s  = rem_shift_s - {1'b0, opnd_r};
    if (!rem_diff_s[DATA_W]) begin
      rem_next_s = rem_diff_s[DATA_W-1:0];
      quo_next_s = {acc_r[DATA_W-2:0], 1'b1};
    end else begin
      rem_next_s = rem_shift_s[DATA_W-1:0];
      quo_next_s = {acc_r[DATA_W-2:0], 1'b0};
    end
  end

  // Unsigned result as seen by the sign-correction stage.
  always_comb begin
    if (md_is_div(op_r)) begin
      raw_s = {rem_r, acc_r[DATA_W-1:0]};
    end else begin
      raw_s = acc_r;
    end
  end

  muldiv_sign_fix #(
    .DATA_W (DATA_W)
  ) u_sign_fix (
    .raw_result  (raw_s),
    .op          (op_r),
    .sign_a      (sign_a_r),
    .sign_b      (sign_b_r),
    .div_by_zero (dbz_r),
    .a_orig      (a_orig_r),
    .result      (fixed_s)
  );

  // Next-state logic; Flush always returns to IDLE and blocks a launch.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (Flush) begin
          state_s = IDLE;
        end else if (Start) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (Flush) begin
          state_s = IDLE;
        end else if (cnt_r == CNT_W'(1)) begin
          state_s = FIX;
        end else begin
          state_s = RUN;
        end
      end
      FIX: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath registers: operand latch at launch, one step per RUN cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      op_r     <= MD_MULT;
      sign_a_r <= 1'b0;
      sign_b_r <= 1'b0;
      dbz_r    <= 1'b0;
      a_orig_r <= {DATA_W{1'b0}};
      opnd_r   <= {DATA_W{1'b0}};
      acc_r    <= {(2*DATA_W){1'b0}};
      rem_r    <= {DATA_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (Start && !Flush) begin
            op_r     <= op_s;
            sign_a_r <= sign_a_s;
            sign_b_r <= sign_b_s;
            dbz_r    <= dbz_s;
            a_orig_r <= A;
            rem_r    <= {DATA_W{1'b0}};
            cnt_r    <= CNT_W'(DATA_W);
            if (md_is_div(op_s)) begin
              opnd_r <= abs_b_s;
              acc_r  <= {{DATA_W{1'b0}}, abs_a_s};
            end else begin
              opnd_r <= abs_a_s;
              acc_r  <= {{DATA_W{1'b0}}, abs_b_s};
            end
          end
        end
        RUN: begin
          cnt_r <= cnt_r - CNT_W'(1);
          if (md_is_div(op_r)) begin
            rem_r <= rem_next_s;
            acc_r <= {acc_r[2*DATA_W-1:DATA_W], quo_next_s};
          end else begin
            acc_r <= mul_next_s;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // HI/LO: result write in FIX, MTHI/MTLO only while idle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      hi_r <= {DATA_W{1'b0}};
      lo_r <= {DATA_W{1'b0}};
    end else if (state_r == FIX && !Flush) begin
      hi_r <= fixed_s[2*DATA_W-1:DATA_W];
      lo_r <= fixed_s[DATA_W-1:0];
    end else if (state_r == IDLE) begin
      if (HiWrite) begin
        hi_r <= WrData;
      end
      if (LoWrite) begin
        lo_r <= WrData;
      end
    end
  end

  // Registered status: Busy tracks the next state, Done marks the HI/LO write.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_s != IDLE);
      done_r <= (state_r == FIX) && !Flush;
    end
  end

  assign Busy = busy_r;
  assign Done = done_r;
  assign Hi   = hi_r;
  assign Lo   = lo_r;

endmodule
